// File: rtl/sw_debounce_pkg.sv
// Shared defaults and helpers for the slide-switch debouncer.
// Import with: import sw_debounce_pkg::*;
package sw_debounce_pkg;

  localparam int unsigned SW_WIDTH_DEF    = 8;
  localparam int unsigned CLK_HZ_DEF      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS_DEF = 10;

  // Converts a debounce window in milliseconds into a number of clock cycles.
  function automatic int unsigned stable_cycles(input int unsigned clk_hz,
                                                input int unsigned ms);
    return (clk_hz / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-side signal bundle of the debouncer: raw pins in, clean level and strobes out.
interface sw_debounce_if
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH = SW_WIDTH_DEF
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  // Board / stimulus side.
  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed
  );

  // Debouncer side.
  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output sw_changed
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch channel: 2-FF synchroniser, stability counter, clean level and edge strobes.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = stable_cycles(CLK_HZ_DEF, DEBOUNCE_MS_DEF)
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             flip;

  // A full window of disagreement flips the clean level; any agreement drops all credit.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    flip    = 1'b0;
    if (sync2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      flip    = 1'b1;
      cnt_d   = '0;
      clean_d = ~clean_q;
      rise_d  = ~clean_q;
      fall_d  = clean_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean  = clean_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  // Next-cycle strobe, used by the parent to register the combined change flag.
  assign toggle = flip;

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH slide switches and flags every clean-level transition.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = SW_WIDTH_DEF,
  parameter int unsigned STABLE_CYCLES = stable_cycles(CLK_HZ_DEF, DEBOUNCE_MS_DEF)
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  sw_debounce_if.slave  sw
);

  logic [WIDTH-1:0] clean_v;
  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] fall_v;
  logic [WIDTH-1:0] toggle_v;
  logic             changed_q, changed_d;

  for (genvar g = 0; g < WIDTH; g++) begin : gen_ch
    sw_debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .raw          (sw.sw_raw[g]),
      .clean        (clean_v[g]),
      .rise         (rise_v[g]),
      .fall         (fall_v[g]),
      .toggle       (toggle_v[g])
    );
  end

  // Registered from the channels' next-cycle toggles so it lines up with rise/fall.
  always_comb begin
    changed_d = |toggle_v;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign sw.sw_clean   = clean_v;
  assign sw.sw_rise    = rise_v;
  assign sw.sw_fall    = fall_v;
  assign sw.sw_changed = changed_q;

endmodule
